// File: rtl/register_file_scoreboard.sv
// rtl/register_file_scoreboard.sv - parametrised register file with write bypass and busy scoreboard
// Decode reads operands and hazard flags combinationally; writeback writes and clears busy bits.
module register_file_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             RegWrite,
    input  logic [ADDR_WIDTH-1:0]            WriteRegister,
    input  logic [DATA_WIDTH-1:0]            WriteData,
    input  logic                             IssueValid,
    input  logic [ADDR_WIDTH-1:0]            IssueDest,
    input  logic                             Flush,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]   ReadRegister,
    output logic [NUM_READ*DATA_WIDTH-1:0]   ReadData,
    output logic [NUM_READ-1:0]              ReadBusy,
    output logic [ADDR_WIDTH:0]              BusyCount
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   r_busy;
    logic [ADDR_WIDTH:0]   r_busy_count;

    logic                  w_wr_en;
    logic [NUM_REGS-1:0]   w_busy_next;
    logic [ADDR_WIDTH:0]   w_popcount;

    assign w_wr_en = RegWrite && !((ZERO_REG != 0) && (WriteRegister == '0));

    // Flush wins over issue, and issue wins over a writeback clear of the same register.
    always_comb begin
        w_busy_next = r_busy;
        if (Flush) begin
            w_busy_next = '0;
        end else begin
            if (RegWrite)
                w_busy_next[WriteRegister] = 1'b0;
            if (IssueValid)
                w_busy_next[IssueDest] = 1'b1;
        end
        if (ZERO_REG != 0)
            w_busy_next[0] = 1'b0;
    end

    always_comb begin
        w_popcount = '0;
        for (int i = 0; i < NUM_REGS; i++)
            w_popcount = w_popcount + {{ADDR_WIDTH{1'b0}}, w_busy_next[i]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= '0;
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            if (w_wr_en)
                r_regs[WriteRegister] <= WriteData;
            r_busy       <= w_busy_next;
            r_busy_count <= w_popcount;
        end
    end

    assign BusyCount = r_busy_count;

    // A writeback to the read index forwards its data and resolves the hazard in the same cycle.
    always_comb begin
        ReadData = '0;
        ReadBusy = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            logic [ADDR_WIDTH-1:0] w_idx;
            logic                  w_hit;
            w_idx = ReadRegister[p*ADDR_WIDTH +: ADDR_WIDTH];
            w_hit = RegWrite && (WriteRegister == w_idx);
            if ((ZERO_REG != 0) && (w_idx == '0)) begin
                ReadData[p*DATA_WIDTH +: DATA_WIDTH] = '0;
                ReadBusy[p] = 1'b0;
            end else begin
                ReadData[p*DATA_WIDTH +: DATA_WIDTH] = w_hit ? WriteData : r_regs[w_idx];
                ReadBusy[p] = r_busy[w_idx] && !w_hit;
            end
        end
    end

endmodule

// File: tb/tb_register_file_scoreboard.sv
// tb/tb_register_file_scoreboard.sv - directed self-checking bench for register_file_scoreboard
module tb_register_file_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_we = 0, a_iv = 0, a_fl = 0;
    logic [4:0]  a_wr = 0, a_id = 0;
    logic [31:0] a_wd = 0;
    logic [9:0]  a_rr = 0;
    logic [63:0] a_rd;
    logic [1:0]  a_rb;
    logic [5:0]  a_bc;

    logic        b_we = 0, b_iv = 0, b_fl = 0;
    logic [4:0]  b_wr = 0, b_id = 0;
    logic [15:0] b_wd = 0;
    logic [19:0] b_rr = 0;
    logic [63:0] b_rd;
    logic [3:0]  b_rb;
    logic [5:0]  b_bc;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    register_file_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG(1)) u_a (
        .clk(clk), .rst(rst),
        .RegWrite(a_we), .WriteRegister(a_wr), .WriteData(a_wd),
        .IssueValid(a_iv), .IssueDest(a_id), .Flush(a_fl),
        .ReadRegister(a_rr), .ReadData(a_rd), .ReadBusy(a_rb), .BusyCount(a_bc)
    );

    register_file_scoreboard #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .NUM_READ(4), .ZERO_REG(0)) u_b (
        .clk(clk), .rst(rst),
        .RegWrite(b_we), .WriteRegister(b_wr), .WriteData(b_wd),
        .IssueValid(b_iv), .IssueDest(b_id), .Flush(b_fl),
        .ReadRegister(b_rr), .ReadData(b_rd), .ReadBusy(b_rb), .BusyCount(b_bc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] idx;

        step();
        step();
        chk("rst_bc_a", a_bc, 0);
        chk("rst_bc_b", b_bc, 0);
        for (int i = 0; i < 32; i++) begin
            idx  = i[4:0];
            a_rr = {idx, idx};
            #1;
            chk("rst_rd0", a_rd[31:0], 0);
            chk("rst_rd1", a_rd[63:32], 0);
            chk("rst_rb", a_rb, 0);
        end
        rst = 0;

        // reset during a write discards it
        a_we = 1; a_wr = 5; a_wd = 32'hDEADBEEF;
        step();
        a_we = 0;
        a_wr = 5; a_wd = 32'hDEADBEEF; a_we = 1; rst = 1;
        step();
        rst = 0; a_we = 0; a_rr = {5'd0, 5'd5};
        #1 chk("rst_midwrite_r5", a_rd[31:0], 0);
        step();
        chk("rst_midwrite_r5_later", a_rd[31:0], 0);

        // bypass then stored
        a_we = 1; a_wr = 3; a_wd = 32'h12345678; a_rr = {5'd5, 5'd3};
        #1 chk("bypass_r3", a_rd[31:0], 32'h12345678);
        chk("bypass_other_port", a_rd[63:32], 0);
        step();
        a_we = 0;
        #1 chk("stored_r3", a_rd[31:0], 32'h12345678);

        // r0 hardwired
        a_we = 1; a_wr = 0; a_wd = 32'hFFFFFFFF; a_rr = {5'd3, 5'd0};
        #1 chk("r0_bypass_blocked", a_rd[31:0], 0);
        step();
        a_we = 0;
        #1 chk("r0_stored", a_rd[31:0], 0);
        chk("r3_port1", a_rd[63:32], 32'h12345678);

        // issue r7, writeback resolves in same cycle
        a_iv = 1; a_id = 7; a_rr = {5'd0, 5'd7};
        #1 chk("issue_not_same_cycle", a_rb, 0);
        step();
        a_iv = 0;
        #1 chk("r7_busy", a_rb, 2'b01);
        chk("bc_one", a_bc, 1);
        a_we = 1; a_wr = 7; a_wd = 32'hA5;
        #1 chk("r7_bypass_busy", a_rb, 0);
        chk("r7_bypass_data", a_rd[31:0], 32'hA5);
        chk("bc_before_edge", a_bc, 1);
        step();
        a_we = 0;
        #1 chk("bc_after_wb", a_bc, 0);
        chk("r7_not_busy", a_rb, 0);
        chk("r7_data", a_rd[31:0], 32'hA5);

        // issue and write same register: busy wins
        a_iv = 1; a_id = 9; a_we = 1; a_wr = 9; a_wd = 32'h55;
        step();
        a_iv = 0; a_we = 0; a_rr = {5'd9, 5'd0};
        #1 chk("r9_data", a_rd[63:32], 32'h55);
        chk("r9_busy", a_rb, 2'b10);
        chk("r9_bc", a_bc, 1);
        a_iv = 1; a_id = 9;
        step();
        a_iv = 0;
        chk("r9_reissue_bc", a_bc, 1);

        // issue r12 while writing busy r9: one set, one cleared
        a_iv = 1; a_id = 12; a_we = 1; a_wr = 9; a_wd = 32'h56;
        step();
        a_iv = 0; a_we = 0; a_rr = {5'd12, 5'd9};
        #1 chk("swap_bc", a_bc, 1);
        chk("swap_busy", a_rb, 2'b10);
        a_we = 1; a_wr = 12; a_wd = 32'h0;
        step();
        a_we = 0;
        chk("swap_clear_bc", a_bc, 0);

        // r0 never busy
        a_iv = 1; a_id = 0; a_rr = 10'd0;
        step();
        a_iv = 0;
        chk("r0_issue_bc", a_bc, 0);
        chk("r0_issue_rb", a_rb, 0);

        // flush beats issue and write-clear; data write still happens
        for (int i = 1; i <= 4; i++) begin
            a_iv = 1; a_id = i[4:0];
            step();
        end
        a_iv = 0;
        chk("bc_four", a_bc, 4);
        a_fl = 1; a_we = 1; a_wr = 2; a_wd = 32'h77; a_iv = 1; a_id = 5;
        step();
        a_fl = 0; a_we = 0; a_iv = 0; a_rr = {5'd5, 5'd2};
        #1 chk("flush_bc", a_bc, 0);
        chk("flush_data_r2", a_rd[31:0], 32'h77);
        chk("flush_busy", a_rb, 0);

        // wide configuration: every register busy, four ports
        for (int i = 0; i < 32; i++) begin
            b_iv = 1; b_id = i[4:0];
            step();
        end
        b_iv = 0;
        chk("b_bc_full", b_bc, 32);
        b_we = 1; b_wr = 0;  b_wd = 16'h1111; step();
        b_wr = 31; b_wd = 16'hBEEF; step();
        b_wr = 15; b_wd = 16'h0F0F; step();
        b_we = 0;
        chk("b_bc_29", b_bc, 29);
        b_rr = {5'd15, 5'd31, 5'd31, 5'd0};
        #1 chk("b_p0_r0", b_rd[15:0], 16'h1111);
        chk("b_p1_r31", b_rd[31:16], 16'hBEEF);
        chk("b_p2_r31", b_rd[47:32], 16'hBEEF);
        chk("b_p3_r15", b_rd[63:48], 16'h0F0F);
        chk("b_rb_clear", b_rb, 4'b0000);
        b_rr = {5'd1, 5'd31, 5'd31, 5'd0};
        #1 chk("b_rb_r1", b_rb, 4'b1000);
        b_fl = 1;
        step();
        b_fl = 0;
        chk("b_flush_bc", b_bc, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/register_file_scoreboard.md
Name: register_file_scoreboard

Overview:
Parametrised successor to the processor register file. It is configurable in data width, register count and number of read ports. It adds a same-cycle write-to-read bypass and a per-register busy scoreboard, so decode can detect RAW hazards on results still in flight (loads, multi-cycle ops). It sits between decode (read and issue side) and writeback (write side).

Parameters:
DATA_WIDTH, 32, width of each register and data port
ADDR_WIDTH, 5, register index width; register count = 2**ADDR_WIDTH
NUM_READ, 2, number of independent combinational read ports (1..4)
ZERO_REG, 1, 1 = register 0 is hardwired to zero and never busy; 0 = register 0 is an ordinary register

Ports:
clk  input  1  clock, all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
RegWrite  input  1  writeback enable
WriteRegister  input  ADDR_WIDTH  writeback destination index
WriteData  input  DATA_WIDTH  writeback value
IssueValid  input  1  an instruction with a pending result is issued this cycle
IssueDest  input  ADDR_WIDTH  destination of the issued instruction
Flush  input  1  pipeline flush; clears every busy bit
ReadRegister  input  NUM_READ*ADDR_WIDTH  packed read indices; port p uses bits [p*ADDR_WIDTH +: ADDR_WIDTH]
ReadData  output  NUM_READ*DATA_WIDTH  packed read data, same packing
ReadBusy  output  NUM_READ  per-port flag: source operand not yet valid
BusyCount  output  ADDR_WIDTH+1  number of registers currently marked busy

Behaviour:
- Reset (asynchronous, rst=1): all registers = 0, all busy bits = 0, BusyCount = 0. ReadData therefore reads 0 and ReadBusy = 0 while rst is held. Reset asserted mid-operation discards any in-flight write or issue that cycle.
- Write: at the edge where RegWrite=1, reg[WriteRegister] <= WriteData.
  - With ZERO_REG=1, writes to index 0 are ignored; reg 0 always reads 0.
- Read, combinational, per port p:
  - Index 0 with ZERO_REG=1 -> 0.
  - Else if RegWrite=1 and WriteRegister equals the index -> WriteData (bypass; zero-latency forwarding).
  - Else -> stored reg[index].
  - Any combination of ports may read the same index.
- Scoreboard, per register r:
  - Set at the edge when IssueValid=1 and IssueDest=r.
  - Cleared at the edge when RegWrite=1 and WriteRegister=r.
  - Priority: Flush > issue set > write clear. Flush=1 clears all busy bits regardless of other inputs. The register data write still occurs during a flush.
  - Simultaneous issue and write to the same r: data is written and busy ends at 1, because the new producer supersedes the old one.
  - Issue to an already-busy r: busy stays 1 (no counting of multiple producers).
  - Index 0 with ZERO_REG=1 is never set busy.
- ReadBusy[p] = busy[index_p] AND NOT (RegWrite AND WriteRegister == index_p). Bypass resolves the hazard in the same cycle. With ZERO_REG=1, index 0 always gives ReadBusy=0. IssueValid in the current cycle does not affect ReadBusy until the next cycle.
- BusyCount: registered population count of the busy vector, updated on the same edge as the busy bits so it always matches the busy vector. Range 0..2**ADDR_WIDTH; full width avoids overflow when every register is busy (ZERO_REG=0).
- Timing: write latency 1 cycle (next-cycle read sees stored data). Bypass makes the write visible in the same cycle. Scoreboard set/clear latency 1 cycle.

Test Plan:
- Reset then read all 32 indices on both ports -> ReadData=0, ReadBusy=0, BusyCount=0. Assert rst mid-write of 0xDEADBEEF to r5 -> r5 reads 0 after release.
- Write r3=0x12345678 while port0 reads r3 in the same cycle -> ReadData0=0x12345678 (bypass). Next cycle, with RegWrite=0 -> still 0x12345678. Write r0=0xFFFFFFFF (ZERO_REG=1) -> r0 reads 0.
- IssueValid, IssueDest=7 -> next cycle ReadBusy=1 for a port reading r7, BusyCount=1. Writeback r7=0xA5 -> ReadBusy=0 in that same cycle, ReadData=0xA5. After the edge, BusyCount=0.
- Same cycle: IssueDest=9 and RegWrite to r9=0x55 -> r9 stored as 0x55, busy[9]=1, BusyCount=1. Issue r9 again -> BusyCount stays 1.
- Issue r1..r4 over 4 cycles (BusyCount=4), then Flush together with a write of r2=0x77 -> all busy cleared, BusyCount=0, r2 reads 0x77.
- NUM_READ=4, DATA_WIDTH=16, ZERO_REG=0: issue all 32 registers -> BusyCount=32 (no overflow). Four ports read r0, r31, r31, r15 concurrently with correct independent data.
